// File: rtl/ack_bus_sched.sv
// Bus acknowledge scheduler: fixed-priority or round-robin grant of a shared
// bus, with one-cycle turnaround between owners and an optional hold timeout.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req[N]         per-source level request (bit i = source ID i)
//   done[N]        per-source release strobe, honoured for the owner only
//   ack_ready[N]   registered one-hot grant (or zero)
//   winner_id      registered ID of current / most recent owner
//   ack_event      one-cycle pulse in the first cycle of each grant
//   busy           state is GRANT or TURN
//   timeout_evt    one-cycle pulse when a grant is revoked by timeout alone
module ack_bus_sched #(
  parameter int NUM_SRC     = 4,
  parameter int ID_W        = 2,
  parameter int MODE        = 0,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] done,
  output logic [NUM_SRC-1:0] ack_ready,
  output logic [ID_W-1:0]    winner_id,
  output logic               ack_event,
  output logic               busy,
  output logic               timeout_evt
);

  localparam int CNT_W =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int TO_LAST_I =
    (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TO_LAST_I);
  localparam logic [ID_W-1:0] LAST_ID =
    ID_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_TURN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_SRC-1:0] r_ack;
  logic [NUM_SRC-1:0] w_ack_nxt;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    w_id_nxt;
  logic               r_evt;
  logic               w_evt_nxt;
  logic               r_to;
  logic               w_to_nxt;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic               w_found;
  logic [ID_W-1:0]    w_win;
  logic               w_own_req;
  logic               w_own_done;
  logic               w_to_hit;
  logic               w_rel;

  // Winner search. Round-robin walks upward from r_ptr with wrap.
  always_comb begin : win_sel
    logic [ID_W-1:0] v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = r_ptr;
    if (MODE == 0) begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (req[i]) begin
          w_found = 1'b1;
          w_win   = ID_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (!w_found && req[v_idx]) begin
          w_found = 1'b1;
          w_win   = v_idx;
        end
        v_idx = (v_idx == LAST_ID) ? '0 : v_idx + 1'b1;
      end
    end
  end

  assign w_own_req  = req[r_id];
  assign w_own_done = done[r_id];
  assign w_to_hit   = (TIMEOUT_CYC > 0) && (r_cnt == TO_LAST);
  assign w_rel      = w_own_done | ~w_own_req | w_to_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    w_id_nxt    = r_id;
    w_evt_nxt   = 1'b0;
    w_to_nxt    = 1'b0;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_ack_nxt   = NUM_SRC'(1) << w_win;
          w_id_nxt    = w_win;
          w_evt_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = (w_win == LAST_ID) ? '0 : w_win + 1'b1;
        end
      end
      S_GRANT: begin
        if (w_rel) begin
          w_state_nxt = S_TURN;
          w_ack_nxt   = '0;
          // An owner-side release outranks a coincident timeout.
          w_to_nxt    = w_to_hit & w_own_req & ~w_own_done;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_TURN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ack_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack <= '0;
      r_id  <= '0;
      r_evt <= 1'b0;
      r_to  <= 1'b0;
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      r_ack <= w_ack_nxt;
      r_id  <= w_id_nxt;
      r_evt <= w_evt_nxt;
      r_to  <= w_to_nxt;
      r_ptr <= w_ptr_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign ack_ready   = r_ack;
  assign winner_id   = r_id;
  assign ack_event   = r_evt;
  assign timeout_evt = r_to;
  assign busy        = (r_state != S_IDLE);

  a_onehot : assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0(ack_ready)
  );

endmodule

// File: tb/tb_ack_bus_sched.sv
// Self-checking bench for ack_bus_sched: fixed-priority vector table,
// round-robin, no-timeout hold, timeout and reset-mid-grant sequences.
module tb_ack_bus_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] req_a = '0, done_a = '0, ack_a;
  logic [1:0] id_a;
  logic       evt_a, busy_a, to_a;
  logic [3:0] req_b = '0, done_b = '0, ack_b;
  logic [1:0] id_b;
  logic       evt_b, busy_b, to_b;
  logic [3:0] req_c = '0, done_c = '0, ack_c;
  logic [1:0] id_c;
  logic       evt_c, busy_c, to_c;

  ack_bus_sched #(.NUM_SRC(4), .ID_W(2), .MODE(0), .TIMEOUT_CYC(16)) ua (
    .clk(clk), .rst_n(rst_n), .req(req_a), .done(done_a),
    .ack_ready(ack_a), .winner_id(id_a), .ack_event(evt_a),
    .busy(busy_a), .timeout_evt(to_a));

  ack_bus_sched #(.NUM_SRC(4), .ID_W(2), .MODE(1), .TIMEOUT_CYC(0)) ub (
    .clk(clk), .rst_n(rst_n), .req(req_b), .done(done_b),
    .ack_ready(ack_b), .winner_id(id_b), .ack_event(evt_b),
    .busy(busy_b), .timeout_evt(to_b));

  ack_bus_sched #(.NUM_SRC(4), .ID_W(2), .MODE(0), .TIMEOUT_CYC(4)) uc (
    .clk(clk), .rst_n(rst_n), .req(req_c), .done(done_c),
    .ack_ready(ack_c), .winner_id(id_c), .ack_event(evt_c),
    .busy(busy_c), .timeout_evt(to_c));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] ack;
    logic [1:0] id;
    logic       evt;
    logic       busy;
    logic       to;
  } vec_t;

  typedef struct {
    logic [3:0] ack;
    logic       to;
    logic       evt;
  } tvec_t;

  vec_t  tv[17];
  tvec_t tt[7];
  int    rr_exp[5];

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    int   hold;

    tv[0]  = '{4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0};
    tv[1]  = '{4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0};
    tv[2]  = '{4'b1010, 4'b1000, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0};
    tv[3]  = '{4'b1000, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0};
    tv[4]  = '{4'b1000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0};
    tv[6]  = '{4'b1000, 4'b0001, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b0};
    tv[7]  = '{4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b1, 1'b0};
    tv[8]  = '{4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0};
    tv[9]  = '{4'b0000, 4'b1111, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0};
    tv[10] = '{4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0};
    tv[11] = '{4'b0111, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0};
    tv[12] = '{4'b0101, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0};
    tv[13] = '{4'b0101, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};
    tv[14] = '{4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};
    tv[15] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0};
    tv[16] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};

    tt[0] = '{4'b0100, 1'b0, 1'b1};
    tt[1] = '{4'b0100, 1'b0, 1'b0};
    tt[2] = '{4'b0100, 1'b0, 1'b0};
    tt[3] = '{4'b0100, 1'b0, 1'b0};
    tt[4] = '{4'b0000, 1'b1, 1'b0};
    tt[5] = '{4'b0000, 1'b0, 1'b0};
    tt[6] = '{4'b0100, 1'b0, 1'b1};

    rr_exp = '{0, 1, 2, 3, 0};

    // Reset state
    #12;
    chk("reset_a", {ack_a, id_a, evt_a, busy_a, to_a}, 0);
    chk("reset_b", {ack_b, id_b, evt_b, busy_b, to_b}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed priority vector table
    for (int i = 0; i < 17; i++) begin
      req_a  = tv[i].req;
      done_a = tv[i].done;
      step();
      chk($sformatf("fp_vec%0d", i),
          {ack_a, id_a, evt_a, busy_a, to_a},
          {tv[i].ack, tv[i].id, tv[i].evt, tv[i].busy, tv[i].to});
    end
    done_a = '0;

    // Round-robin: all requesting, done each grant
    req_b = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      got = 1'b0;
      for (int k = 0; k < 4 && !got; k++) begin
        step();
        if (evt_b) got = 1'b1;
      end
      chk($sformatf("rr_grant_seen%0d", n), got, 1);
      chk($sformatf("rr_id%0d", n), id_b, rr_exp[n]);
      done_b = 4'b0001 << id_b;
      step();
      done_b = '0;
      chk($sformatf("rr_turn%0d", n), {ack_b, busy_b}, {4'b0000, 1'b1});
    end

    // No timeout: grant to 2 holds indefinitely
    req_b = 4'b0100;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      step();
      if (evt_b) got = 1'b1;
    end
    chk("hold_grant_seen", got, 1);
    chk("hold_id", id_b, 2);
    hold = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (ack_b == 4'b0100) hold++;
    end
    chk("hold_cycles", hold, 20);

    // Reset mid-grant, asynchronous
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_b", {ack_b, id_b, evt_b, busy_b, to_b}, 0);
    req_b = 4'b0101;
    @(negedge clk);
    chk("rst_held_b", {ack_b, busy_b}, 0);
    rst_n = 1'b1;
    step();
    chk("rst_regrant", {ack_b, id_b, evt_b}, {4'b0001, 2'd0, 1'b1});
    req_b = '0;

    // Timeout after 4 cycles, then re-grant after TURN and IDLE
    req_c = 4'b0100;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("to_cyc%0d", i), {ack_c, to_c, evt_c},
          {tt[i].ack, tt[i].to, tt[i].evt});
    end

    // done coinciding with timeout: release without timeout_evt
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("to_hold%0d", i), ack_c, 4'b0100);
    end
    done_c = 4'b0100;
    step();
    done_c = '0;
    req_c  = '0;
    chk("to_done_wins", {ack_c, to_c, busy_c}, {4'b0000, 1'b0, 1'b1});
    step();
    chk("to_idle", {ack_c, to_c, busy_c}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
